// File: rtl/slc3_pkg.sv
// Shared types and encodings for the SLC-3 control unit: state enum, opcodes,
// mux/ALU select codes and the per-state control-word decode.
package slc3_pkg;

   typedef enum logic [4:0] {
      HALTED, S18, S33, S35, S32,
      S01, S05, S09, S00, S22, S12,
      S06, S25, S27, S07, S23, S16,
      PAUSE1, PAUSE2
   } state_t;

   localparam logic [3:0] OP_BR    = 4'b0000;
   localparam logic [3:0] OP_ADD   = 4'b0001;
   localparam logic [3:0] OP_AND   = 4'b0101;
   localparam logic [3:0] OP_NOT   = 4'b1001;
   localparam logic [3:0] OP_JMP   = 4'b1100;
   localparam logic [3:0] OP_LDR   = 4'b0110;
   localparam logic [3:0] OP_STR   = 4'b0111;
   localparam logic [3:0] OP_PAUSE = 4'b1101;

   localparam logic [1:0] PCMUX_PC1   = 2'b00;
   localparam logic [1:0] PCMUX_BUS   = 2'b01;
   localparam logic [1:0] PCMUX_ADDER = 2'b10;

   localparam logic [1:0] ADDR2_ZERO  = 2'b00;
   localparam logic [1:0] ADDR2_OFF6  = 2'b01;
   localparam logic [1:0] ADDR2_OFF9  = 2'b10;
   localparam logic [1:0] ADDR2_OFF11 = 2'b11;

   localparam logic [1:0] ALUK_ADD  = 2'b00;
   localparam logic [1:0] ALUK_AND  = 2'b01;
   localparam logic [1:0] ALUK_NOT  = 2'b10;
   localparam logic [1:0] ALUK_PASS = 2'b11;

   typedef struct packed {
      logic       ld_mar;
      logic       ld_mdr;
      logic       ld_ir;
      logic       ld_pc;
      logic       ld_reg;
      logic       ld_cc;
      logic       ld_led;
      logic       gate_pc;
      logic       gate_mdr;
      logic       gate_alu;
      logic       gate_marmux;
      logic [1:0] pcmux;
      logic       drmux;
      logic       sr1mux;
      logic       sr2mux;
      logic       addr1mux;
      logic [1:0] addr2mux;
      logic [1:0] aluk;
      logic       mem_oe;
      logic       mem_we;
   } ctrl_t;

   // Pure state-to-control-word table; IR-dependent and entry-only bits are
   // patched in by the caller.
   function automatic ctrl_t state_ctrl(input state_t s);
      ctrl_t c;
      c = '0;
      case (s)
         S18: begin
            c.gate_pc = 1'b1;
            c.ld_mar  = 1'b1;
            c.pcmux   = PCMUX_PC1;
            c.ld_pc   = 1'b1;
         end
         S33, S25: begin
            c.mem_oe = 1'b1;
            c.ld_mdr = 1'b1;
         end
         S35: begin
            c.gate_mdr = 1'b1;
            c.ld_ir    = 1'b1;
         end
         S01, S05, S09: begin
            c.aluk     = (s == S01) ? ALUK_ADD : ((s == S05) ? ALUK_AND : ALUK_NOT);
            c.gate_alu = 1'b1;
            c.ld_reg   = 1'b1;
            c.ld_cc    = 1'b1;
         end
         S22: begin
            c.addr1mux = 1'b0;
            c.addr2mux = ADDR2_OFF9;
            c.pcmux    = PCMUX_ADDER;
            c.ld_pc    = 1'b1;
         end
         S12: begin
            c.aluk     = ALUK_PASS;
            c.gate_alu = 1'b1;
            c.pcmux    = PCMUX_BUS;
            c.ld_pc    = 1'b1;
         end
         S06, S07: begin
            c.addr1mux    = 1'b1;
            c.addr2mux    = ADDR2_OFF6;
            c.gate_marmux = 1'b1;
            c.ld_mar      = 1'b1;
         end
         S27: begin
            c.gate_mdr = 1'b1;
            c.ld_reg   = 1'b1;
            c.ld_cc    = 1'b1;
         end
         S23: begin
            c.aluk     = ALUK_PASS;
            c.gate_alu = 1'b1;
            c.ld_mdr   = 1'b1;
         end
         S16:     c.mem_we = 1'b1;
         PAUSE1:  c.ld_led = 1'b1;
         default: c = '0;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/slc3_ctrl.sv
// SLC-3 control FSM: sequences bus gates, load enables and memory strobes,
// and holds the branch-enable bit computed at decode.
module slc3_ctrl
   import slc3_pkg::*;
#(
   parameter int MEM_WAIT = 2
) (
   input  logic       Clk,
   input  logic       Reset_n,
   input  logic       Run,
   input  logic       Continue,
   input  logic [15:0] IR,
   input  logic       n,
   input  logic       z,
   input  logic       p,
   output logic       LD_MAR,
   output logic       LD_MDR,
   output logic       LD_IR,
   output logic       LD_PC,
   output logic       LD_REG,
   output logic       LD_CC,
   output logic       LD_LED,
   output logic       GatePC,
   output logic       GateMDR,
   output logic       GateALU,
   output logic       GateMARMUX,
   output logic [1:0] PCMUX,
   output logic       DRMUX,
   output logic       SR1MUX,
   output logic       SR2MUX,
   output logic       ADDR1MUX,
   output logic [1:0] ADDR2MUX,
   output logic [1:0] ALUK,
   output logic       Mem_OE,
   output logic       Mem_WE,
   output logic       BEN,
   output state_t     dbg_state_o
);

   localparam int CW = (MEM_WAIT < 1) ? 1 : $clog2(MEM_WAIT + 1);
   localparam logic [CW-1:0] WAIT_LAST = CW'(MEM_WAIT - 1);

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          ben_q, ben_d;
   ctrl_t         ctrl_q, ctrl_d;

   logic unused_ir;
   assign unused_ir = ^{IR[8:6], IR[4:0]};

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      ben_d   = ben_q;
      case (state_q)
         HALTED: if (Run) state_d = S18;
         S18: begin
            state_d = S33;
            cnt_d   = '0;
         end
         S33: begin
            if (cnt_q == WAIT_LAST) state_d = S35;
            else                    cnt_d   = cnt_q + 1'b1;
         end
         S35: state_d = S32;
         S32: begin
            ben_d = (IR[11] & n) | (IR[10] & z) | (IR[9] & p);
            case (IR[15:12])
               OP_ADD:   state_d = S01;
               OP_AND:   state_d = S05;
               OP_NOT:   state_d = S09;
               OP_BR:    state_d = S00;
               OP_JMP:   state_d = S12;
               OP_LDR:   state_d = S06;
               OP_STR:   state_d = S07;
               OP_PAUSE: state_d = PAUSE1;
               default:  state_d = S18;
            endcase
         end
         // BEN was written on the edge into S00, so this reads the fresh value.
         S00: state_d = ben_q ? S22 : S18;
         S06: begin
            state_d = S25;
            cnt_d   = '0;
         end
         S25: begin
            if (cnt_q == WAIT_LAST) state_d = S27;
            else                    cnt_d   = cnt_q + 1'b1;
         end
         S07: state_d = S23;
         S23: begin
            state_d = S16;
            cnt_d   = '0;
         end
         S16: begin
            if (cnt_q == WAIT_LAST) state_d = S18;
            else                    cnt_d   = cnt_q + 1'b1;
         end
         PAUSE1: if (Continue)  state_d = PAUSE2;
         PAUSE2: if (!Continue) state_d = S18;
         S01, S05, S09, S22, S12, S27: state_d = S18;
         default: state_d = HALTED;
      endcase
   end

   // Outputs are registered from the next state so they line up with state_q.
   always_comb begin
      ctrl_d        = state_ctrl(state_d);
      ctrl_d.sr2mux = ((state_d == S01) || (state_d == S05)) & IR[5];
      ctrl_d.ld_led = (state_d == PAUSE1) && (state_q != PAUSE1);
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q <= HALTED;
         cnt_q   <= '0;
         ben_q   <= 1'b0;
         ctrl_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         ben_q   <= ben_d;
         ctrl_q  <= ctrl_d;
      end
   end

   assign LD_MAR      = ctrl_q.ld_mar;
   assign LD_MDR      = ctrl_q.ld_mdr;
   assign LD_IR       = ctrl_q.ld_ir;
   assign LD_PC       = ctrl_q.ld_pc;
   assign LD_REG      = ctrl_q.ld_reg;
   assign LD_CC       = ctrl_q.ld_cc;
   assign LD_LED      = ctrl_q.ld_led;
   assign GatePC      = ctrl_q.gate_pc;
   assign GateMDR     = ctrl_q.gate_mdr;
   assign GateALU     = ctrl_q.gate_alu;
   assign GateMARMUX  = ctrl_q.gate_marmux;
   assign PCMUX       = ctrl_q.pcmux;
   assign DRMUX       = ctrl_q.drmux;
   assign SR1MUX      = ctrl_q.sr1mux;
   assign SR2MUX      = ctrl_q.sr2mux;
   assign ADDR1MUX    = ctrl_q.addr1mux;
   assign ADDR2MUX    = ctrl_q.addr2mux;
   assign ALUK        = ctrl_q.aluk;
   assign Mem_OE      = ctrl_q.mem_oe;
   assign Mem_WE      = ctrl_q.mem_we;
   assign BEN         = ben_q;
   assign dbg_state_o = state_q;

endmodule

// File: tb/tb_slc3_ctrl.sv
// Scoreboard bench for slc3_ctrl: the driver pushes the hand-derived per-cycle
// control word for each instruction; the monitor pops and compares every cycle.
module tb_slc3_ctrl;
   import slc3_pkg::*;

   localparam int MW = 2;

   // Control-word bit layout, MSB first, matching act_w below.
   localparam logic [23:0] M_LD_MAR   = 24'h80_0000;
   localparam logic [23:0] M_LD_MDR   = 24'h40_0000;
   localparam logic [23:0] M_LD_IR    = 24'h20_0000;
   localparam logic [23:0] M_LD_PC    = 24'h10_0000;
   localparam logic [23:0] M_LD_REG   = 24'h08_0000;
   localparam logic [23:0] M_LD_CC    = 24'h04_0000;
   localparam logic [23:0] M_LD_LED   = 24'h02_0000;
   localparam logic [23:0] M_GPC      = 24'h01_0000;
   localparam logic [23:0] M_GMDR     = 24'h00_8000;
   localparam logic [23:0] M_GALU     = 24'h00_4000;
   localparam logic [23:0] M_GMARMUX  = 24'h00_2000;
   localparam logic [23:0] M_PC_BUS   = 24'h00_0800;
   localparam logic [23:0] M_PC_ADDER = 24'h00_1000;
   localparam logic [23:0] M_SR2      = 24'h00_0100;
   localparam logic [23:0] M_ADDR1    = 24'h00_0080;
   localparam logic [23:0] M_A2_OFF6  = 24'h00_0020;
   localparam logic [23:0] M_A2_OFF9  = 24'h00_0040;
   localparam logic [23:0] M_ALU_AND  = 24'h00_0008;
   localparam logic [23:0] M_ALU_NOT  = 24'h00_0010;
   localparam logic [23:0] M_ALU_PASS = 24'h00_0018;
   localparam logic [23:0] M_MEM_OE   = 24'h00_0004;
   localparam logic [23:0] M_MEM_WE   = 24'h00_0002;

   localparam logic [23:0] E_ZERO = 24'h0;
   localparam logic [23:0] E_S18  = M_GPC | M_LD_MAR | M_LD_PC;
   localparam logic [23:0] E_S33  = M_MEM_OE | M_LD_MDR;
   localparam logic [23:0] E_S35  = M_GMDR | M_LD_IR;
   localparam logic [23:0] E_ALU  = M_GALU | M_LD_REG | M_LD_CC;
   localparam logic [23:0] E_S22  = M_A2_OFF9 | M_PC_ADDER | M_LD_PC;
   localparam logic [23:0] E_S12  = M_ALU_PASS | M_GALU | M_PC_BUS | M_LD_PC;
   localparam logic [23:0] E_S06  = M_ADDR1 | M_A2_OFF6 | M_GMARMUX | M_LD_MAR;
   localparam logic [23:0] E_S27  = M_GMDR | M_LD_REG | M_LD_CC;
   localparam logic [23:0] E_S23  = M_ALU_PASS | M_GALU | M_LD_MDR;

   logic        Clk, Reset_n, Run, Continue, n, z, p;
   logic [15:0] IR;
   logic        LD_MAR, LD_MDR, LD_IR, LD_PC, LD_REG, LD_CC, LD_LED;
   logic        GatePC, GateMDR, GateALU, GateMARMUX;
   logic [1:0]  PCMUX, ADDR2MUX, ALUK;
   logic        DRMUX, SR1MUX, SR2MUX, ADDR1MUX, Mem_OE, Mem_WE, BEN;
   state_t      dbg_state;
   logic [23:0] act_w;

   int          n_tests = 0;
   int          n_fail  = 0;
   logic [23:0] exp_q[$];
   string       tag_q[$];
   logic        ben_e;

   slc3_ctrl #(.MEM_WAIT(MW)) dut (
      .Clk(Clk), .Reset_n(Reset_n), .Run(Run), .Continue(Continue), .IR(IR),
      .n(n), .z(z), .p(p),
      .LD_MAR(LD_MAR), .LD_MDR(LD_MDR), .LD_IR(LD_IR), .LD_PC(LD_PC),
      .LD_REG(LD_REG), .LD_CC(LD_CC), .LD_LED(LD_LED),
      .GatePC(GatePC), .GateMDR(GateMDR), .GateALU(GateALU), .GateMARMUX(GateMARMUX),
      .PCMUX(PCMUX), .DRMUX(DRMUX), .SR1MUX(SR1MUX), .SR2MUX(SR2MUX),
      .ADDR1MUX(ADDR1MUX), .ADDR2MUX(ADDR2MUX), .ALUK(ALUK),
      .Mem_OE(Mem_OE), .Mem_WE(Mem_WE), .BEN(BEN), .dbg_state_o(dbg_state)
   );

   assign act_w = {LD_MAR, LD_MDR, LD_IR, LD_PC, LD_REG, LD_CC, LD_LED,
                   GatePC, GateMDR, GateALU, GateMARMUX, PCMUX, DRMUX, SR1MUX,
                   SR2MUX, ADDR1MUX, ADDR2MUX, ALUK, Mem_OE, Mem_WE, BEN};

   // Clock and watchdog
   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Monitor: samples after each falling clock edge, and right after a reset
   // assertion so the asynchronous clear is seen before any rising edge.
   initial begin
      logic [23:0] act, e;
      string       t;
      forever begin
         @(negedge Clk or negedge Reset_n);
         #1;
         act = act_w;
         n_tests++;
         if ($countones({GatePC, GateMDR, GateALU, GateMARMUX}) > 1) begin
            n_fail++;
            $display("FAIL gate_onehot: gates=%b, required at most one high",
                     {GatePC, GateMDR, GateALU, GateMARMUX});
         end
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            n_tests++;
            if (act !== e) begin
               n_fail++;
               $display("FAIL %s: got %h expected %h (t=%0t)", t, act, e, $time);
            end
         end
      end
   end

   // Driver tasks: all input changes happen 3 time units after a falling edge.
   task automatic idle(input int k);
      repeat (k) begin
         @(negedge Clk);
         #3;
      end
   endtask

   task automatic push(input logic [23:0] v, input string t);
      exp_q.push_back(v | {23'b0, ben_e});
      tag_q.push_back(t);
   endtask

   task automatic push_fetch();
      push(E_S18, "fetch_S18");
      for (int i = 0; i < MW; i++) push(E_S33, "fetch_S33");
      push(E_S35, "fetch_S35");
      push(E_ZERO, "decode_S32");
   endtask

   task automatic drain();
      int b;
      b = 0;
      while (exp_q.size() > 0 && b < 200) begin
         idle(1);
         b++;
      end
      if (exp_q.size() > 0) begin
         n_tests++;
         n_fail++;
         $display("FAIL drain_timeout: %0d entries left, required 0", exp_q.size());
         exp_q.delete();
         tag_q.delete();
      end
   endtask

   task automatic do_reset();
      Run     = 1'b0;
      Reset_n = 1'b0;
      idle(1);
      Reset_n = 1'b1;
   endtask

   task automatic start(input logic [15:0] ir, input logic nn, input logic zz, input logic pp);
      do_reset();
      IR       = ir;
      n        = nn;
      z        = zz;
      p        = pp;
      Continue = 1'b0;
      ben_e    = 1'b0;
      Run      = 1'b1;
      push_fetch();
   endtask

   initial begin
      Reset_n  = 1'b0;
      Run      = 1'b0;
      Continue = 1'b0;
      IR       = 16'h0000;
      n        = 1'b0;
      z        = 1'b0;
      p        = 1'b0;
      ben_e    = 1'b0;
      idle(2);
      Reset_n = 1'b1;

      // Idle in HALTED, then Run, then reset in the first S33 cycle.
      for (int i = 0; i < 3; i++) push(E_ZERO, "halted_idle");
      drain();
      IR  = 16'h1261;
      Run = 1'b1;
      push(E_S18, "run_S18");
      push(E_S33, "run_S33");
      drain();
      push(E_ZERO, "reset_async_S33");
      Reset_n = 1'b0;
      drain();
      idle(1);
      Run     = 1'b0;
      Reset_n = 1'b1;
      for (int i = 0; i < 3; i++) push(E_ZERO, "halted_after_reset");
      drain();

      // ADD with immediate operand
      start(16'h1261, 1'b0, 1'b0, 1'b0);
      push(E_ALU | M_SR2, "add_S01");
      push(E_S18, "add_return");
      drain();

      // AND with register operand
      start(16'h5042, 1'b0, 1'b0, 1'b0);
      push(E_ALU | M_ALU_AND, "and_S05");
      push(E_S18, "and_return");
      drain();

      // NOT
      start(16'h9640, 1'b0, 1'b0, 1'b0);
      push(E_ALU | M_ALU_NOT, "not_S09");
      push(E_S18, "not_return");
      drain();

      // BRz taken
      start(16'h0402, 1'b0, 1'b1, 1'b0);
      ben_e = 1'b1;
      push(E_ZERO, "brz_taken_S00");
      push(E_S22, "brz_taken_S22");
      push(E_S18, "brz_taken_return");
      drain();

      // BRz not taken with n set
      start(16'h0402, 1'b1, 1'b0, 1'b0);
      push(E_ZERO, "brz_nt_S00");
      push(E_S18, "brz_nt_return");
      drain();

      // JMP
      start(16'hC1C0, 1'b0, 1'b0, 1'b0);
      push(E_S12, "jmp_S12");
      push(E_S18, "jmp_return");
      drain();

      // LDR
      start(16'h6443, 1'b0, 1'b0, 1'b0);
      push(E_S06, "ldr_S06");
      for (int i = 0; i < MW; i++) push(E_S33, "ldr_S25");
      push(E_S27, "ldr_S27");
      push(E_S18, "ldr_return");
      drain();

      // STR
      start(16'h7443, 1'b0, 1'b0, 1'b0);
      push(E_S06, "str_S07");
      push(E_S23, "str_S23");
      for (int i = 0; i < MW; i++) push(M_MEM_WE, "str_S16");
      push(E_S18, "str_return");
      drain();

      // Unsupported opcode falls straight back to fetch
      start(16'h3000, 1'b0, 1'b0, 1'b0);
      push(E_S18, "unknown_return");
      drain();

      // PAUSE: LED pulse, hold, Continue high must pass through PAUSE2
      start(16'hD00F, 1'b0, 1'b0, 1'b0);
      push(M_LD_LED, "pause1_entry");
      push(E_ZERO, "pause1_hold");
      push(E_ZERO, "pause1_hold");
      drain();
      Continue = 1'b1;
      for (int i = 0; i < 3; i++) push(E_ZERO, "pause2_hold");
      drain();
      Continue = 1'b0;
      push(E_S18, "pause_release_S18");
      drain();

      idle(2);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
